// File: rtl/qm_icache_pkg.sv
// qm_icache_pkg: widths, line field offsets and fill FSM states shared by the icache fill path.
package qm_icache_pkg;
   localparam int TAG_W     = 16;
   localparam int INDEX_W   = 12;
   localparam int LINE_W    = 145;
   localparam int VALID_BIT = 144;
   localparam int TAG_HI    = 143;
   localparam int TAG_LO    = 128;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} fill_state_e;
endpackage

// File: rtl/qm_icache_fill.sv
// qm_icache_fill: refills one 4-word icache line from memory in fixed word order 0..3,
// then writes {valid, tag, w3..w0} to the cache; a bus error drops the fill.
module qm_icache_fill #(
   parameter int TAG_W   = qm_icache_pkg::TAG_W,
   parameter int INDEX_W = qm_icache_pkg::INDEX_W,
   parameter int LINE_W  = qm_icache_pkg::LINE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               miss_req,
   input  logic [31:0]        miss_addr,
   input  logic               valid_bit,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_ack,
   input  logic               mem_err,
   input  logic [31:0]        mem_rdata,
   output logic               line_we,
   output logic [INDEX_W-1:0] line_index,
   output logic [LINE_W-1:0]  line_data,
   output logic               busy,
   output logic               fill_done,
   output logic               fill_err
);
   import qm_icache_pkg::*;

   fill_state_e        state_q, state_d;
   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] index_q;
   logic [1:0]         cnt_q, cnt_d;
   logic [3:0][31:0]   words_q;
   logic               fill_err_q, fill_err_d;
   logic               fetch, word_ok;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // mem_err wins over mem_ack in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = miss_req ? S_FETCH : S_IDLE;
         S_FETCH: state_d = mem_err ? S_IDLE : (mem_ack && cnt_q == 2'd3) ? S_WRITE : S_FETCH;
         S_WRITE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = state_q == S_FETCH;
      line_we    = state_q == S_WRITE;
      fill_done  = state_q == S_DONE;
      busy       = state_q != S_IDLE;
      fill_err   = fill_err_q;
      mem_addr   = {tag_q, index_q, cnt_q, 2'b00};
      line_index = index_q;
      line_data  = {valid_bit, tag_q, words_q};
   end

   always_comb begin
      fetch      = state_q == S_FETCH;
      word_ok    = fetch && mem_ack && !mem_err;
      cnt_d      = (state_q == S_IDLE) ? 2'd0 : word_ok ? cnt_q + 2'd1 : cnt_q;
      fill_err_d = fetch && mem_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= 2'd0;
         fill_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         fill_err_q <= fill_err_d;
      end
   end

   // partial words left behind by an aborted fill are simply overwritten by the next one
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && miss_req) begin
         tag_q   <= miss_addr[31 -: TAG_W];
         index_q <= miss_addr[4 +: INDEX_W];
      end
      if (word_ok) words_q[cnt_q] <= mem_rdata;
   end
endmodule

// File: tb/tb_qm_icache_fill.sv
// tb_qm_icache_fill: drives miss/fill transactions with random data, wait states and errors,
// and checks the cache-side results against expectations derived from the fill rules.
module tb_qm_icache_fill;
   import qm_icache_pkg::*;

   logic clk = 1'b0;
   logic reset, miss_req, valid_bit, mem_ack, mem_err;
   logic [31:0] miss_addr, mem_rdata, mem_addr;
   logic mem_req, line_we, busy, fill_done, fill_err;
   logic [INDEX_W-1:0] line_index;
   logic [LINE_W-1:0] line_data;

   int errors = 0, checks = 0;
   bit noise = 0, use_base = 0;
   logic [31:0] data_base;

   logic [31:0] obs_addr[4];
   logic [31:0] exp_words[4];
   logic [LINE_W-1:0] obs_line;
   logic [INDEX_W-1:0] obs_index;
   logic obs_v;
   int obs_unstable, obs_we_cycle, obs_we_cnt, obs_done_cycle, obs_done_cnt;
   int obs_err_cycle, obs_err_cnt, obs_busy_first, obs_busy_last, obs_busy_cnt, obs_post_busy, obs_timeout;

   always #5 clk = ~clk;

   qm_icache_fill dut (
      .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr), .valid_bit(valid_bit),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
      .line_we(line_we), .line_index(line_index), .line_data(line_data),
      .busy(busy), .fill_done(fill_done), .fill_err(fill_err)
   );

   // Issues one miss from IDLE and plays the memory: each word waits `waits` cycles then is acked,
   // or errored if it is word err_word. Records what the cache side saw; leaves the DUT in IDLE.
   task automatic run_fill(input logic [31:0] addr, input int waits, input int err_word, input int vmode,
                           input bit hold_miss, input bit tamper);
      int w = 0, wc = 0, term = 1000;
      for (int i = 0; i < 4; i++) obs_addr[i] = 'x;
      obs_unstable = 0; obs_we_cycle = -1; obs_we_cnt = 0; obs_done_cycle = -1; obs_done_cnt = 0;
      obs_err_cycle = -1; obs_err_cnt = 0; obs_busy_first = -1; obs_busy_last = -1; obs_busy_cnt = 0;
      obs_post_busy = -1; obs_timeout = 0; obs_line = '0; obs_index = '0; obs_v = 0;
      miss_req = 1; miss_addr = addr;
      valid_bit = (vmode == 2) ? 1'($urandom) : vmode[0];
      mem_ack = noise ? 1'($urandom) : 1'b0;
      mem_err = noise ? 1'($urandom) : 1'b0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(posedge clk); #1;
         if (vmode == 2) valid_bit = 1'($urandom);
         #1;
         if (!hold_miss) miss_req = 0;
         if (tamper) miss_addr = 32'hFFFF_FFF0;
         if (cyc == term + 1) begin
            obs_post_busy = busy; miss_req = 0; mem_ack = 0; mem_err = 0;
            return;
         end
         if (busy) begin
            if (obs_busy_first < 0) obs_busy_first = cyc;
            obs_busy_last = cyc; obs_busy_cnt++;
         end
         if (line_we) begin
            obs_we_cnt++; obs_we_cycle = cyc; obs_line = line_data; obs_index = line_index; obs_v = valid_bit;
         end
         if (fill_done) begin obs_done_cnt++; obs_done_cycle = cyc; term = cyc; end
         if (fill_err) begin obs_err_cnt++; obs_err_cycle = cyc; term = cyc; miss_req = 0; end
         mem_ack = noise ? 1'($urandom) : 1'b0;
         mem_err = noise ? 1'($urandom) : 1'b0;
         mem_rdata = $urandom;
         if (mem_req) begin
            mem_ack = 0; mem_err = 0;
            if (w < 4) begin
               if (wc == 0) obs_addr[w] = mem_addr;
               else if (mem_addr !== obs_addr[w]) obs_unstable++;
               if (wc < waits) wc++;
               else if (w == err_word) begin mem_err = 1; mem_ack = 1'($urandom); end
               else begin
                  if (use_base) mem_rdata = data_base + 32'(w);
                  mem_ack = 1; exp_words[w] = mem_rdata; w++; wc = 0;
               end
            end
         end
      end
      obs_timeout = 1;
      miss_req = 0; mem_ack = 0; mem_err = 0;
   endtask

   task automatic test_reset();
      int bad = 0;
      reset = 1; miss_req = 1; miss_addr = $urandom; valid_bit = 1; mem_ack = 1; mem_err = 1; mem_rdata = $urandom;
      repeat (3) begin
         @(posedge clk); #2;
         if ({mem_req, line_we, busy, fill_done, fill_err} !== 5'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_outputs: %0d cycles with outputs nonzero, required 0", bad); end
      reset = 0; miss_req = 0; mem_ack = 0; mem_err = 0;
      @(posedge clk); #2;
      checks++;
      if ({busy, mem_req, fill_err} !== 3'b0) begin
         errors++; $display("FAIL reset_release: busy/mem_req/fill_err=%b required 000", {busy, mem_req, fill_err});
      end
   endtask

   task automatic test_basic();
      noise = 0; use_base = 1; data_base = 32'hA0;
      run_fill(32'h1234_5670, 0, -1, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] ea;
         ea = 32'h1234_5670 + 32'(4 * k);
         checks++;
         if (obs_addr[k] !== ea) begin errors++; $display("FAIL basic_addr%0d: got %h required %h", k, obs_addr[k], ea); end
      end
      checks++;
      if (obs_we_cycle !== 5 || obs_we_cnt !== 1) begin
         errors++; $display("FAIL basic_we: cycle %0d count %0d, required cycle 5 count 1", obs_we_cycle, obs_we_cnt);
      end
      checks++;
      if (obs_index !== 12'h567) begin errors++; $display("FAIL basic_index: got %h required 567", obs_index); end
      checks++;
      if (obs_line !== {1'b1, 16'h1234, 32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
         errors++; $display("FAIL basic_line: got %h", obs_line);
      end
      checks++;
      if (obs_done_cycle !== 6 || obs_busy_first !== 1 || obs_busy_last !== 6 || obs_post_busy !== 0) begin
         errors++; $display("FAIL basic_timing: done %0d busy %0d..%0d post %0d, required 6, 1..6, 0",
                            obs_done_cycle, obs_busy_first, obs_busy_last, obs_post_busy);
      end
      use_base = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      a = $urandom;
      run_fill(a, 0, -1, 1, 0, 0);
      checks++;
      if (obs_addr[0] !== {a[31:4], 4'h0} || obs_we_cycle !== 5 || obs_line !== {1'b1, a[31:16], exp_words[3], exp_words[2], exp_words[1], exp_words[0]}) begin
         errors++; $display("FAIL back_to_back: addr0 %h we_cycle %0d line %h", obs_addr[0], obs_we_cycle, obs_line);
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] a;
      a = $urandom;
      run_fill(a, 3, -1, 1, 0, 0);
      checks++;
      if (obs_unstable !== 0) begin errors++; $display("FAIL wait_addr_stable: %0d changes, required 0", obs_unstable); end
      checks++;
      if (obs_addr[3] !== {a[31:4], 4'hC}) begin errors++; $display("FAIL wait_addr3: got %h required %h", obs_addr[3], {a[31:4], 4'hC}); end
      checks++;
      if (obs_we_cycle !== 17) begin errors++; $display("FAIL wait_we_cycle: got %0d required 17", obs_we_cycle); end
      checks++;
      if (obs_busy_first !== 1 || obs_busy_last !== 18 || obs_busy_cnt !== 18) begin
         errors++; $display("FAIL wait_busy: %0d..%0d (%0d cycles), required 1..18", obs_busy_first, obs_busy_last, obs_busy_cnt);
      end
   endtask

   task automatic test_bus_error();
      int p;
      p = $urandom_range(1, 3);
      noise = 0;
      run_fill($urandom, p - 1, 2, 1, 0, 0);
      checks++;
      if (obs_err_cnt !== 1 || obs_err_cycle !== 3 * p + 1) begin
         errors++; $display("FAIL err_pulse: count %0d cycle %0d, required 1 at %0d", obs_err_cnt, obs_err_cycle, 3 * p + 1);
      end
      checks++;
      if (obs_we_cnt !== 0 || obs_done_cnt !== 0 || obs_post_busy !== 0) begin
         errors++; $display("FAIL err_abort: we %0d done %0d post_busy %0d, required 0 0 0", obs_we_cnt, obs_done_cnt, obs_post_busy);
      end
      test_back_to_back();
   endtask

   task automatic test_reset_mid_fill();
      int bad = 0;
      miss_req = 1; miss_addr = $urandom; mem_ack = 0; mem_err = 0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #2;
         if (line_we) bad++;
         miss_req = 0; mem_ack = mem_req; mem_rdata = $urandom;
      end
      reset = 1; miss_req = 1;
      @(posedge clk); #2;
      checks++;
      if ({mem_req, line_we, busy, fill_done, fill_err} !== 5'b0) begin
         errors++; $display("FAIL reset_mid_outputs: got %b required 00000", {mem_req, line_we, busy, fill_done, fill_err});
      end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         reset = 0; miss_req = 0; mem_ack = 0;
         if (line_we || fill_done || fill_err || busy) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_mid_quiet: %0d cycles with activity, required 0", bad); end
   endtask

   task automatic test_addr_change();
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFE0;
      run_fill(a, $urandom_range(0, 2), -1, 1, 1, 1);
      checks++;
      if (obs_index !== a[15:4] || obs_line[TAG_HI:TAG_LO] !== a[31:16]) begin
         errors++; $display("FAIL addr_change: index %h tag %h, required %h %h", obs_index, obs_line[TAG_HI:TAG_LO], a[15:4], a[31:16]);
      end
      checks++;
      if (obs_addr[2] !== {a[31:4], 4'h8} || obs_we_cnt !== 1) begin
         errors++; $display("FAIL addr_change_fetch: addr2 %h we %0d, required %h 1", obs_addr[2], obs_we_cnt, {a[31:4], 4'h8});
      end
   endtask

   task automatic test_valid_and_done();
      run_fill($urandom, 0, -1, 0, 1, 0);
      checks++;
      if (obs_line[VALID_BIT] !== 1'b0 || obs_we_cnt !== 1) begin
         errors++; $display("FAIL valid_zero: valid %b we %0d, required 0 1", obs_line[VALID_BIT], obs_we_cnt);
      end
      checks++;
      if (obs_done_cnt !== 1 || obs_post_busy !== 0) begin
         errors++; $display("FAIL done_ignores_miss: done %0d post_busy %0d, required 1 0", obs_done_cnt, obs_post_busy);
      end
   endtask

   task automatic test_random();
      noise = 1;
      for (int n = 0; n < 25; n++) begin
         logic [31:0] a;
         logic [LINE_W-1:0] el;
         int waits, ew, vm, p, nw, bad;
         a = $urandom; waits = $urandom_range(0, 3); vm = $urandom_range(0, 2);
         ew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
         run_fill(a, waits, ew, vm, 1'($urandom), 1'($urandom));
         p = waits + 1; nw = (ew < 0) ? 4 : ew + 1; bad = 0;
         for (int k = 0; k < nw; k++) if (obs_addr[k] !== {a[31:4], k[1:0], 2'b00}) bad++;
         checks++;
         if (bad != 0 || obs_unstable != 0 || obs_timeout != 0) begin
            errors++; $display("FAIL rnd%0d_fetch: %0d bad addrs %0d unstable timeout %0d", n, bad, obs_unstable, obs_timeout);
         end
         checks++;
         if (obs_post_busy !== 0 || obs_busy_first !== 1 || obs_busy_last !== ((ew < 0) ? 4 * p + 2 : nw * p)) begin
            errors++; $display("FAIL rnd%0d_busy: %0d..%0d post %0d", n, obs_busy_first, obs_busy_last, obs_post_busy);
         end
         if (ew >= 0) begin
            checks++;
            if (obs_err_cnt !== 1 || obs_err_cycle !== nw * p + 1 || obs_we_cnt !== 0 || obs_done_cnt !== 0) begin
               errors++; $display("FAIL rnd%0d_err: err %0d@%0d we %0d done %0d, required err 1@%0d", n,
                                  obs_err_cnt, obs_err_cycle, obs_we_cnt, obs_done_cnt, nw * p + 1);
            end
         end else begin
            el = {(vm == 2) ? obs_v : vm[0], a[31:16], exp_words[3], exp_words[2], exp_words[1], exp_words[0]};
            checks++;
            if (obs_line !== el || obs_index !== a[15:4]) begin
               errors++; $display("FAIL rnd%0d_line: got %h/%h required %h/%h", n, obs_line, obs_index, el, a[15:4]);
            end
            checks++;
            if (obs_we_cnt !== 1 || obs_we_cycle !== 4 * p + 1 || obs_done_cnt !== 1 || obs_done_cycle !== 4 * p + 2 || obs_err_cnt !== 0) begin
               errors++; $display("FAIL rnd%0d_timing: we %0d@%0d done %0d@%0d err %0d, required we@%0d done@%0d", n,
                                  obs_we_cnt, obs_we_cycle, obs_done_cnt, obs_done_cycle, obs_err_cnt, 4 * p + 1, 4 * p + 2);
            end
         end
      end
      noise = 0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      reset = 1; miss_req = 0; miss_addr = 0; valid_bit = 0; mem_ack = 0; mem_err = 0; mem_rdata = 0; data_base = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_wait_states();
      test_bus_error();
      test_reset_mid_fill();
      test_addr_change();
      test_valid_and_done();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qm_icache_fill.md
QM_ICACHE_FILL -- requirements
Module: qm_icache_fill

Interface
REQ-001 SHALL have parameter TAG_W, default 16, cache tag width (address[31:16]).
REQ-002 SHALL have parameter INDEX_W, default 12, cache line index width (address[15:4]).
REQ-003 SHALL have parameter LINE_W, default 145, line width: {valid[144], tag[143:128], w3, w2, w1, w0}.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 miss_req  input  1  cache miss/stall indication from the instruction cache.
REQ-007 miss_addr  input  32  fetch address that missed.
REQ-008 valid_bit  input  1  current valid-marker polarity of the cache.
REQ-009 mem_req  output  1  memory word-read request.
REQ-010 mem_addr  output  32  word-aligned memory read address.
REQ-011 mem_ack  input  1  word accepted; mem_rdata valid this cycle.
REQ-012 mem_err  input  1  bus error for the current request; takes priority over mem_ack.
REQ-013 mem_rdata  input  32  read data.
REQ-014 line_we  output  1  one-cycle cache line write strobe.
REQ-015 line_index  output  INDEX_W  line to write.
REQ-016 line_data  output  LINE_W  assembled line.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 fill_done  output  1  one-cycle pulse on successful fill.
REQ-019 fill_err  output  1  one-cycle pulse on aborted fill.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, WRITE, and DONE.
REQ-021 In IDLE with miss_req=1: latch tag=miss_addr[31:16] and index=miss_addr[15:4], clear word counter, go to FETCH next cycle.
REQ-022 In FETCH: mem_req=1 and mem_addr={tag, index, cnt[1:0], 2'b00}; mem_addr stable until ack/err.
REQ-023 On mem_ack in FETCH: store mem_rdata into word slot cnt; cnt==3 -> WRITE, else cnt+1 and stay in FETCH.
REQ-024 Word order SHALL be fixed at 0,1,2,3 (no critical-word-first).
REQ-025 On mem_err in FETCH: pulse fill_err next cycle, discard partial data, return to IDLE with no line_we.
REQ-026 In WRITE: line_we=1 for exactly one cycle, line_index=latched index, line_data={valid_bit, tag, w3, w2, w1, w0}; then DONE.
REQ-027 The valid_bit SHALL be sampled in the WRITE cycle.
REQ-028 In DONE: fill_done=1 for one cycle and miss_req ignored (cache settles); then IDLE.
REQ-029 Latency with mem_ack every cycle: miss seen at cycle 0, FETCH cycles 1-4, line_we at cycle 5, fill_done at cycle 6, next miss accepted at cycle 7.
REQ-030 Changes on miss_addr/miss_req outside IDLE SHALL be ignored.
REQ-031 mem_ack/mem_err outside FETCH SHALL be ignored.
REQ-032 Outputs SHALL be registered or decoded from state only; no combinational path from mem_* to mem_req.

Reset
REQ-033 Reset SHALL force IDLE, cnt=0, and mem_req, line_we, busy, fill_done, fill_err all 0.
REQ-034 Reset mid-fill SHALL abort with no line_we and no done/err pulse.
REQ-035 Reset SHALL override all inputs in the same cycle.
REQ-036 line_data, line_index, and mem_addr are don't-care while their strobes are low.

Structure
REQ-037 Shared package qm_icache_pkg SHALL hold TAG_W, INDEX_W, LINE_W, field offsets (VALID_BIT=144, TAG_HI=143, TAG_LO=128), and the fill-state enum.
REQ-038 The block SHALL be a single module with no sub-module; the line buffer is 4x32 registers inside.

Verification
REQ-039 miss_addr=0x1234_5670, ack every cycle, rdata=0xA0..0xA3 -> mem_addr 0x12345670/74/78/7C on cycles 1-4; line_we at cycle 5 with index 0x567, line_data={1,0x1234,0xA3,0xA2,0xA1,0xA0}.
REQ-040 Ack with 3 wait cycles per word -> mem_addr held stable across waits; line_we at cycle 17; busy high cycles 1-18.
REQ-041 mem_err on word 2 -> fill_err pulse, no line_we, IDLE, next miss_req accepted.
REQ-042 reset asserted on cycle 3 of fill -> all outputs 0 next cycle; no line_we ever issued.
REQ-043 miss_addr changed to 0xFFFF_FFF0 during FETCH -> fill completes with the original tag/index.
REQ-044 valid_bit=0 at WRITE -> line_data[144]=0; miss_req high during DONE -> no new fill until IDLE.
